// File: rtl/cmos_capture_gate_pkg.sv
// Shared definitions for the DVP capture gate: state codes, counter widths
// and the RGB565 line-length helper.
package cmos_cap_pkg;

   typedef logic [1:0] cap_state_t;

   localparam cap_state_t SETTLE = 2'd0;
   localparam cap_state_t IDLE   = 2'd1;
   localparam cap_state_t ARMED  = 2'd2;
   localparam cap_state_t ACTIVE = 2'd3;

   localparam int unsigned BYTE_W = 12;
   localparam int unsigned LINE_W = 11;

   // RGB565: two bytes per pixel
   function automatic logic [16:0] line_bytes(input logic [15:0] h);
      return {h, 1'b0};
   endfunction

endpackage

// File: rtl/cmos_capture_gate_if.sv
// Gated image stream from the capture front end to the packetiser.
interface cmos_capture_gate_if;

   logic       img_vsync;
   logic       img_data_en;
   logic [7:0] img_data;

   modport master (output img_vsync, output img_data_en, output img_data);
   modport slave  (input  img_vsync, input  img_data_en, input  img_data);

endinterface

// File: rtl/cmos_capture_gate_dvp_sync_edge.sv
// Two-stage register of the raw DVP bus with vsync/href edge detection.
module dvp_sync_edge (
   input  logic       clk,
   input  logic       rst,
   input  logic       vsync,
   input  logic       href,
   input  logic [7:0] data,
   output logic       d0_href,
   output logic [7:0] d0_data,
   output logic       d1_href,
   output logic       rise,
   output logic       fall,
   output logic       href_fall
);

   logic d0_vs;
   logic d1_vs;

   always_ff @(posedge clk) begin
      if (rst) begin
         d0_vs   <= 1'b0;
         d0_href <= 1'b0;
         d0_data <= '0;
         d1_vs   <= 1'b0;
         d1_href <= 1'b0;
      end else begin
         d0_vs   <= vsync;
         d0_href <= href;
         d0_data <= data;
         d1_vs   <= d0_vs;
         d1_href <= d0_href;
      end
   end

   assign rise      =  d0_vs   & ~d1_vs;
   assign fall      = ~d0_vs   &  d1_vs;
   assign href_fall = ~d0_href &  d1_href;

endmodule

// File: rtl/cmos_capture_gate.sv
// DVP capture front end: skips settling frames, forwards whole frames only
// while transfer_flag is set, and checks each forwarded frame's geometry.
module cmos_capture_gate
   import cmos_cap_pkg::*;
#(
   parameter logic [15:0] H_PIXEL    = 16'd640,
   parameter logic [15:0] V_PIXEL    = 16'd480,
   parameter logic [3:0]  FRAME_SKIP = 4'd10
) (
   input  logic                cam_pclk,
   input  logic                rst,
   input  logic                cam_vsync,
   input  logic                cam_href,
   input  logic [7:0]          cam_data,
   input  logic                transfer_flag,
   cmos_capture_gate_if.master img,
   output logic                capture_active,
   output logic                frame_done,
   output logic                frame_err,
   output logic [15:0]         frame_cnt
);

   localparam logic [16:0] LB = line_bytes(H_PIXEL);

   logic              d0_hr;
   logic [7:0]        d0_data;
   logic              d1_hr;
   logic              rise;
   logic              fall;
   logic              href_fall;

   cap_state_t        state;
   cap_state_t        state_nxt;
   logic [3:0]        skip_cnt;
   logic [BYTE_W-1:0] byte_cnt;
   logic [BYTE_W-1:0] byte_inc;
   logic [LINE_W-1:0] line_cnt;
   logic [LINE_W-1:0] line_nxt;
   logic              err_acc;
   logic              err_nxt;
   logic              active;
   logic              line_close;
   logic              skip_hit;

   dvp_sync_edge u_sync (
      .clk       (cam_pclk),
      .rst       (rst),
      .vsync     (cam_vsync),
      .href      (cam_href),
      .data      (cam_data),
      .d0_href   (d0_hr),
      .d0_data   (d0_data),
      .d1_href   (d1_hr),
      .rise      (rise),
      .fall      (fall),
      .href_fall (href_fall)
   );

   assign active   = (state == ACTIVE);
   assign skip_hit = ({1'b0, skip_cnt} + 5'd1) >= {1'b0, FRAME_SKIP};

   always_comb begin
      state_nxt = state;
      case (state)
         SETTLE: if (rise && skip_hit)     state_nxt = IDLE;
         IDLE:   if (rise && transfer_flag) state_nxt = ARMED;
         ARMED: begin
            if (!transfer_flag)   state_nxt = IDLE;
            else if (fall)        state_nxt = ACTIVE;
         end
         ACTIVE: if (rise) state_nxt = transfer_flag ? ARMED : IDLE;
         default:          state_nxt = SETTLE;
      endcase
   end

   // A line still open at the closing rise is closed and length-checked in
   // that same cycle, so the frame verdict sees it.
   always_comb begin
      byte_inc = byte_cnt;
      if (active && d0_hr && (byte_cnt != '1))
         byte_inc = byte_cnt + BYTE_W'(1);
      line_close = active && (href_fall || (rise && d1_hr));
      line_nxt   = line_cnt;
      if (line_close && (line_cnt != '1))
         line_nxt = line_cnt + LINE_W'(1);
      err_nxt = err_acc | (line_close && ({5'd0, byte_inc} != LB));
   end

   always_ff @(posedge cam_pclk) begin
      if (rst) begin
         state           <= SETTLE;
         skip_cnt        <= '0;
         byte_cnt        <= '0;
         line_cnt        <= '0;
         err_acc         <= 1'b0;
         img.img_vsync   <= 1'b0;
         img.img_data_en <= 1'b0;
         img.img_data    <= '0;
         frame_done      <= 1'b0;
         frame_err       <= 1'b0;
         frame_cnt       <= '0;
      end else begin
         state <= state_nxt;
         if (state == SETTLE && rise)
            skip_cnt <= skip_cnt + 4'd1;

         img.img_vsync   <= (state_nxt == IDLE) || (state_nxt == ARMED);
         img.img_data_en <= active && d0_hr;
         img.img_data    <= (active && d0_hr) ? d0_data : '0;

         frame_done <= active && rise;
         if (active && rise) begin
            frame_err <= err_nxt | ({5'd0, line_nxt} != V_PIXEL);
            frame_cnt <= frame_cnt + 16'd1;
         end

         if (state == ARMED && state_nxt == ACTIVE) begin
            byte_cnt <= '0;
            line_cnt <= '0;
            err_acc  <= 1'b0;
         end else if (active) begin
            byte_cnt <= line_close ? '0 : byte_inc;
            line_cnt <= line_nxt;
            err_acc  <= err_nxt;
         end
      end
   end

   assign capture_active = active;

endmodule

// File: tb/tb_cmos_capture_gate.sv
// Directed bench for cmos_capture_gate with a small geometry (H=4, V=3, skip 2).
module tb_cmos_capture_gate;

   logic        cam_pclk = 1'b0;
   logic        rst;
   logic        cam_vsync;
   logic        cam_href;
   logic [7:0]  cam_data;
   logic        transfer_flag;
   logic        capture_active;
   logic        frame_done;
   logic        frame_err;
   logic [15:0] frame_cnt;

   cmos_capture_gate_if img_if ();

   cmos_capture_gate #(
      .H_PIXEL    (16'd4),
      .V_PIXEL    (16'd3),
      .FRAME_SKIP (4'd2)
   ) dut (
      .cam_pclk       (cam_pclk),
      .rst            (rst),
      .cam_vsync      (cam_vsync),
      .cam_href       (cam_href),
      .cam_data       (cam_data),
      .transfer_flag  (transfer_flag),
      .img            (img_if),
      .capture_active (capture_active),
      .frame_done     (frame_done),
      .frame_err      (frame_err),
      .frame_cnt      (frame_cnt)
   );

   always #5 cam_pclk = ~cam_pclk;

   int n_assert = 0;
   int n_fail   = 0;

   // Output activity monitor, sampled 1 ns after each rising edge
   int          en_cnt   = 0;
   int          done_cnt = 0;
   int          vs_hi    = 0;
   int          vs_lo    = 0;
   logic        last_err = 1'b0;
   logic [15:0] last_cnt = '0;

   always @(posedge cam_pclk) begin
      #1;
      if (img_if.img_data_en === 1'b1) en_cnt++;
      if (img_if.img_vsync === 1'b1) vs_hi++;
      else vs_lo++;
      if (frame_done === 1'b1) begin
         done_cnt++;
         last_err = frame_err;
         last_cnt = frame_cnt;
      end
   end

   int e0, dn0, h0, l0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic snap();
      e0  = en_cnt;
      dn0 = done_cnt;
      h0  = vs_hi;
      l0  = vs_lo;
   endtask

   task automatic pulse();
      @(negedge cam_pclk) cam_vsync = 1'b1;
      repeat (4) @(negedge cam_pclk);
   endtask

   // One frame: vsync fall, lines with blanking, closing vsync rise.
   task automatic frame(input int nlines, input int short_line, input int short_len,
                        input bit chk_lat, input int tf_line, input bit tf_val);
      int len;
      @(negedge cam_pclk) cam_vsync = 1'b0;
      repeat (2) @(negedge cam_pclk);
      for (int l = 0; l < nlines; l++) begin
         if (l == tf_line) transfer_flag = tf_val;
         len = (l == short_line) ? short_len : 8;
         for (int i = 0; i < len; i++) begin
            @(negedge cam_pclk);
            if (chk_lat && l == 0 && i == 1)
               chk("lat.en_after1", {31'd0, img_if.img_data_en}, 32'd0);
            if (chk_lat && l == 0 && i == 2) begin
               chk("lat.en_after2", {31'd0, img_if.img_data_en}, 32'd1);
               chk("lat.data_after2", {24'd0, img_if.img_data}, 32'hA5);
            end
            cam_href = 1'b1;
            cam_data = (chk_lat && l == 0 && i == 0) ? 8'hA5 : 8'(l * 16 + i);
         end
         @(negedge cam_pclk);
         cam_href = 1'b0;
         cam_data = 8'd0;
         repeat (2) @(negedge cam_pclk);
      end
      @(negedge cam_pclk) cam_vsync = 1'b1;
      repeat (4) @(negedge cam_pclk);
   endtask

   initial begin
      rst           = 1'b1;
      cam_vsync     = 1'b0;
      cam_href      = 1'b0;
      cam_data      = 8'd0;
      transfer_flag = 1'b1;
      repeat (3) @(negedge cam_pclk);

      chk("rst.img_vsync", {31'd0, img_if.img_vsync}, 32'd0);
      chk("rst.img_data_en", {31'd0, img_if.img_data_en}, 32'd0);
      chk("rst.img_data", {24'd0, img_if.img_data}, 32'd0);
      chk("rst.capture_active", {31'd0, capture_active}, 32'd0);
      chk("rst.frame_done", {31'd0, frame_done}, 32'd0);
      chk("rst.frame_cnt", {16'd0, frame_cnt}, 32'd0);
      rst = 1'b0;

      // Settle: two rises consumed, then IDLE, then ARMED, then forwarded
      snap();
      pulse();
      chk("settle.rise1_vs_hi", vs_hi - h0, 32'd0);
      snap();
      frame(3, -1, 0, 1'b0, -1, 1'b0);
      chk("settle.f1_en", en_cnt - e0, 32'd0);
      chk("settle.idle_vsync", {31'd0, img_if.img_vsync}, 32'd1);
      snap();
      frame(3, -1, 0, 1'b0, -1, 1'b0);
      chk("settle.f2_en", en_cnt - e0, 32'd0);
      chk("settle.f2_vs_lo", vs_lo - l0, 32'd0);
      chk("settle.f2_done", done_cnt - dn0, 32'd0);

      // First forwarded frame, also checks pin-to-output latency
      snap();
      frame(3, -1, 0, 1'b1, -1, 1'b0);
      chk("fwd.en", en_cnt - e0, 32'd24);
      chk("fwd.done", done_cnt - dn0, 32'd1);
      chk("fwd.err", {31'd0, last_err}, 32'd0);
      chk("fwd.cnt", {16'd0, last_cnt}, 32'd1);
      chk("fwd.armed_active", {31'd0, capture_active}, 32'd0);

      // transfer_flag drops after line 2: frame completes, next frame idle
      snap();
      frame(3, -1, 0, 1'b0, 2, 1'b0);
      chk("gate.en", en_cnt - e0, 32'd24);
      chk("gate.cnt", {16'd0, last_cnt}, 32'd2);
      chk("gate.err", {31'd0, last_err}, 32'd0);
      snap();
      frame(3, -1, 0, 1'b0, -1, 1'b0);
      chk("gate.next_en", en_cnt - e0, 32'd0);
      chk("gate.next_vs_lo", vs_lo - l0, 32'd0);
      chk("gate.next_done", done_cnt - dn0, 32'd0);

      // transfer_flag rises mid-frame while IDLE
      snap();
      frame(3, -1, 0, 1'b0, 1, 1'b1);
      chk("late.en", en_cnt - e0, 32'd0);
      chk("late.done", done_cnt - dn0, 32'd0);

      // Geometry: short line, then missing line, then clean frame
      snap();
      frame(3, 1, 7, 1'b0, -1, 1'b0);
      chk("geo.short_en", en_cnt - e0, 32'd23);
      chk("geo.short_done", done_cnt - dn0, 32'd1);
      chk("geo.short_err", {31'd0, last_err}, 32'd1);
      chk("geo.short_cnt", {16'd0, last_cnt}, 32'd3);
      snap();
      frame(2, -1, 0, 1'b0, -1, 1'b0);
      chk("geo.lines_en", en_cnt - e0, 32'd16);
      chk("geo.lines_err", {31'd0, last_err}, 32'd1);
      chk("geo.lines_cnt", {16'd0, last_cnt}, 32'd4);
      snap();
      frame(3, -1, 0, 1'b0, -1, 1'b0);
      chk("geo.ok_err", {31'd0, last_err}, 32'd0);
      chk("geo.ok_done", done_cnt - dn0, 32'd1);
      chk("geo.ok_cnt", {16'd0, last_cnt}, 32'd5);

      // Reset in the middle of an active line
      @(negedge cam_pclk) cam_vsync = 1'b0;
      repeat (3) @(negedge cam_pclk);
      cam_href = 1'b1;
      cam_data = 8'h3C;
      repeat (3) @(negedge cam_pclk);
      chk("mid.active", {31'd0, capture_active}, 32'd1);
      chk("mid.en", {31'd0, img_if.img_data_en}, 32'd1);
      rst = 1'b1;
      @(negedge cam_pclk);
      chk("rstmid.en", {31'd0, img_if.img_data_en}, 32'd0);
      chk("rstmid.data", {24'd0, img_if.img_data}, 32'd0);
      chk("rstmid.vsync", {31'd0, img_if.img_vsync}, 32'd0);
      chk("rstmid.active", {31'd0, capture_active}, 32'd0);
      chk("rstmid.cnt", {16'd0, frame_cnt}, 32'd0);
      cam_href = 1'b0;
      cam_data = 8'd0;
      rst      = 1'b0;

      snap();
      pulse();
      frame(3, -1, 0, 1'b0, -1, 1'b0);
      frame(3, -1, 0, 1'b0, -1, 1'b0);
      chk("reskip.en", en_cnt - e0, 32'd0);
      chk("reskip.done", done_cnt - dn0, 32'd0);

      // frame_cnt wrap from 16'hFFFF
      force dut.frame_cnt = 16'hFFFF;
      @(negedge cam_pclk);
      release dut.frame_cnt;
      @(negedge cam_pclk);
      chk("wrap.preload", {16'd0, frame_cnt}, 32'h0000FFFF);
      snap();
      frame(3, -1, 0, 1'b0, -1, 1'b0);
      chk("wrap.done", done_cnt - dn0, 32'd1);
      chk("wrap.cnt", {16'd0, last_cnt}, 32'd0);
      chk("wrap.en", en_cnt - e0, 32'd24);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
